// File: rtl/encoder_type_2_if.sv
// Request/response and memory-write bundle for the type-2 encoder.
// The master side is the producer (crypto datapath or testbench); the
// slave side is the encoder itself.
interface encoder_type_2_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int CODE_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH   = 4,
    parameter int STATE_ADDR_WIDTH = 3
);
    // Producer request
    logic                        encode_start;
    logic [DATA_WIDTH-1:0]       inp_value;
    logic                        inp_sel;
    logic                        overwrite;
    logic [CODE_WIDTH-1:0]       overwrite_code;
    logic                        alloc_clear;

    // Memory write ports
    logic [MEM_ADDR_WIDTH-1:0]   mem_key_val_addr;
    logic [DATA_WIDTH-1:0]       mem_key_val_data_in;
    logic                        mem_key_val_we;
    logic [STATE_ADDR_WIDTH-1:0] mem_state_var_addr;
    logic [DATA_WIDTH-1:0]       mem_state_var_data_in;
    logic                        mem_state_var_we;

    // Completion and status
    logic [CODE_WIDTH-1:0]       out_code;
    logic                        code_ready;
    logic                        error;
    logic                        busy;
    logic                        key_val_full;
    logic                        state_var_full;

    modport master (
        output encode_start, inp_value, inp_sel, overwrite, overwrite_code, alloc_clear,
        input  mem_key_val_addr, mem_key_val_data_in, mem_key_val_we,
        input  mem_state_var_addr, mem_state_var_data_in, mem_state_var_we,
        input  out_code, code_ready, error, busy, key_val_full, state_var_full
    );

    modport slave (
        input  encode_start, inp_value, inp_sel, overwrite, overwrite_code, alloc_clear,
        output mem_key_val_addr, mem_key_val_data_in, mem_key_val_we,
        output mem_state_var_addr, mem_state_var_data_in, mem_state_var_we,
        output out_code, code_ready, error, busy, key_val_full, state_var_full
    );
endinterface

// File: rtl/encoder_type_2.sv
// Type-2 encoder: stores a value into key_val or state_var memory and
// returns the code the type-2 decoder uses to read it back. New entries
// are allocated sequentially per memory; overwrite mode rewrites an
// already-allocated code in place. Interface parameters must match the
// module parameters.
module encoder_type_2 #(
    parameter int DATA_WIDTH       = 32,
    parameter int CODE_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH   = 4,
    parameter int STATE_ADDR_WIDTH = 3,
    parameter int MEM_DELAY        = 2
) (
    input  logic             clock,
    input  logic             resetn,
    encoder_type_2_if.slave  bus
);

    localparam int SEL_BIT    = CODE_WIDTH - 3;
    localparam int WAIT_WIDTH = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;

    localparam logic [MEM_ADDR_WIDTH:0]   KEY_DEPTH   = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};
    localparam logic [STATE_ADDR_WIDTH:0] STATE_DEPTH = {1'b1, {STATE_ADDR_WIDTH{1'b0}}};
    localparam logic [WAIT_WIDTH-1:0]     WAIT_LOAD   = WAIT_WIDTH'(MEM_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT,
        DONE
    } state_t;

    state_t                      state;
    logic [MEM_ADDR_WIDTH:0]     key_count;
    logic [STATE_ADDR_WIDTH:0]   state_count;
    logic [WAIT_WIDTH-1:0]       wait_count;

    logic                        req_sel;
    logic                        req_alloc;
    logic [CODE_WIDTH-1:0]       req_code;

    logic [MEM_ADDR_WIDTH-1:0]   key_addr_q;
    logic [DATA_WIDTH-1:0]       key_data_q;
    logic                        key_we_q;
    logic [STATE_ADDR_WIDTH-1:0] state_addr_q;
    logic [DATA_WIDTH-1:0]       state_data_q;
    logic                        state_we_q;
    logic [CODE_WIDTH-1:0]       out_code_q;
    logic                        code_ready_q;
    logic                        error_q;

    logic                        key_full;
    logic                        state_full;

    logic                        start_sel;
    logic [MEM_ADDR_WIDTH-1:0]   start_key_addr;
    logic [STATE_ADDR_WIDTH-1:0] start_state_addr;
    logic                        start_err;
    logic [CODE_WIDTH-1:0]       start_code;

    // Only the select bit and the low address bits of an overwrite code matter.
    logic unused_code_bits;
    assign unused_code_bits = &{1'b0, bus.overwrite_code};

    assign key_full   = (key_count == KEY_DEPTH);
    assign state_full = (state_count == STATE_DEPTH);

    // Decode the incoming request into target memory, address, code and a reject flag.
    always_comb begin
        start_sel        = bus.overwrite ? bus.overwrite_code[SEL_BIT] : bus.inp_sel;
        start_key_addr   = bus.overwrite ? bus.overwrite_code[MEM_ADDR_WIDTH-1:0]
                                         : key_count[MEM_ADDR_WIDTH-1:0];
        start_state_addr = bus.overwrite ? bus.overwrite_code[STATE_ADDR_WIDTH-1:0]
                                         : state_count[STATE_ADDR_WIDTH-1:0];
        if (bus.overwrite) begin
            start_err = start_sel ? ({1'b0, start_state_addr} >= state_count)
                                  : ({1'b0, start_key_addr} >= key_count);
        end else begin
            start_err = start_sel ? state_full : key_full;
        end
        start_code          = '0;
        start_code[SEL_BIT] = start_sel;
        if (start_sel) begin
            start_code[STATE_ADDR_WIDTH-1:0] = start_state_addr;
        end else begin
            start_code[MEM_ADDR_WIDTH-1:0] = start_key_addr;
        end
    end

    // Request FSM: latch in IDLE, one write cycle, settle for MEM_DELAY, report in DONE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            key_count    <= '0;
            state_count  <= '0;
            wait_count   <= '0;
            req_sel      <= 1'b0;
            req_alloc    <= 1'b0;
            req_code     <= '0;
            key_addr_q   <= '0;
            key_data_q   <= '0;
            key_we_q     <= 1'b0;
            state_addr_q <= '0;
            state_data_q <= '0;
            state_we_q   <= 1'b0;
            out_code_q   <= '0;
            code_ready_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    key_we_q   <= 1'b0;
                    state_we_q <= 1'b0;
                    if (bus.alloc_clear) begin
                        key_count   <= '0;
                        state_count <= '0;
                    end else if (bus.encode_start) begin
                        req_sel   <= start_sel;
                        req_alloc <= !bus.overwrite;
                        req_code  <= start_code;
                        if (start_err) begin
                            state        <= DONE;
                            code_ready_q <= 1'b1;
                            error_q      <= 1'b1;
                            out_code_q   <= '0;
                        end else begin
                            state <= WRITE;
                            if (start_sel) begin
                                state_we_q   <= 1'b1;
                                state_addr_q <= start_state_addr;
                                state_data_q <= bus.inp_value;
                            end else begin
                                key_we_q   <= 1'b1;
                                key_addr_q <= start_key_addr;
                                key_data_q <= bus.inp_value;
                            end
                        end
                    end
                end
                WRITE: begin
                    key_we_q   <= 1'b0;
                    state_we_q <= 1'b0;
                    if (req_alloc) begin
                        if (req_sel && !state_full) begin
                            state_count <= state_count + (STATE_ADDR_WIDTH+1)'(1);
                        end else if (!req_sel && !key_full) begin
                            key_count <= key_count + (MEM_ADDR_WIDTH+1)'(1);
                        end
                    end
                    wait_count <= WAIT_LOAD;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (wait_count == '0) begin
                        state        <= DONE;
                        code_ready_q <= 1'b1;
                        error_q      <= 1'b0;
                        out_code_q   <= req_code;
                    end else begin
                        wait_count <= wait_count - WAIT_WIDTH'(1);
                    end
                end
                DONE: begin
                    code_ready_q <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_key_val_addr      = key_addr_q;
    assign bus.mem_key_val_data_in   = key_data_q;
    assign bus.mem_key_val_we        = key_we_q;
    assign bus.mem_state_var_addr    = state_addr_q;
    assign bus.mem_state_var_data_in = state_data_q;
    assign bus.mem_state_var_we      = state_we_q;
    assign bus.out_code              = out_code_q;
    assign bus.code_ready            = code_ready_q;
    assign bus.error                 = error_q;
    assign bus.busy                  = (state != IDLE);
    assign bus.key_val_full          = key_full;
    assign bus.state_var_full        = state_full;

endmodule

// File: tb/tb_encoder_type_2.sv
// Self-checking bench for encoder_type_2: a vector table, hand-written
// multi-cycle corner sequences, then random requests against a
// counter-and-depth reference model.
module tb_encoder_type_2;

    localparam int DW        = 32;
    localparam int CW        = 8;
    localparam int MAW       = 4;
    localparam int SAW       = 3;
    localparam int MEM_DELAY = 2;
    localparam int SEL_BIT   = CW - 3;

    logic clock;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    // Reference model: allocation count per memory (0 = key_val, 1 = state_var)
    int m_count [2];

    // Memory contents as written by the DUT
    logic [DW-1:0] dut_key_mem   [16];
    logic [DW-1:0] dut_state_mem [8];

    typedef struct {
        logic          sel;
        logic          ow;
        logic [CW-1:0] oc;
        logic [DW-1:0] value;
        logic [CW-1:0] exp_code;
        logic          exp_err;
    } vec_t;

    vec_t vecs [17];

    encoder_type_2_if #(
        .DATA_WIDTH(DW), .CODE_WIDTH(CW), .MEM_ADDR_WIDTH(MAW), .STATE_ADDR_WIDTH(SAW)
    ) bus ();

    encoder_type_2 #(
        .DATA_WIDTH(DW), .CODE_WIDTH(CW), .MEM_ADDR_WIDTH(MAW),
        .STATE_ADDR_WIDTH(SAW), .MEM_DELAY(MEM_DELAY)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every memory write so stored values can be read back like the decoder would
    always @(negedge clock) begin
        if (bus.mem_key_val_we)   dut_key_mem[bus.mem_key_val_addr]     = bus.mem_key_val_data_in;
        if (bus.mem_state_var_we) dut_state_mem[bus.mem_state_var_addr] = bus.mem_state_var_data_in;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int depthOf(input int s);
        return (s == 1) ? 8 : 16;
    endfunction

    // Model one request: returns expected code/error and write target, updates counts
    task automatic modelRequest(input logic sel, input logic ow, input logic [CW-1:0] oc,
                                output logic [CW-1:0] code, output logic err,
                                output logic wsel, output int waddr);
        int s;
        int a;
        if (ow) begin
            s   = int'(oc[SEL_BIT]);
            a   = int'(oc) % depthOf(s);
            err = (a >= m_count[s]);
        end else begin
            s   = int'(sel);
            a   = m_count[s];
            err = (m_count[s] >= depthOf(s));
            if (!err) m_count[s]++;
        end
        code  = err ? '0 : CW'(s * 32 + a);
        wsel  = s[0];
        waddr = a;
    endtask

    task automatic modelClear();
        m_count[0] = 0;
        m_count[1] = 0;
    endtask

    // Issue one request from IDLE and observe it to completion (bounded), ending in IDLE
    task automatic applyStimulus(input logic sel, input logic ow, input logic [CW-1:0] oc,
                                 input logic [DW-1:0] val,
                                 output logic [CW-1:0] code, output logic err, output int lat,
                                 output int writes, output logic wsel, output int waddr,
                                 output logic [DW-1:0] wdata, output logic ready_after);
        code = '0; err = 1'b0; lat = -1; writes = 0; wsel = 1'b0; waddr = -1;
        wdata = '0; ready_after = 1'b0;
        bus.inp_sel        = sel;
        bus.overwrite      = ow;
        bus.overwrite_code = oc;
        bus.inp_value      = val;
        bus.encode_start   = 1'b1;
        @(posedge clock);
        #1 bus.encode_start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clock);
            if (bus.mem_key_val_we) begin
                writes++; wsel = 1'b0;
                waddr = int'(bus.mem_key_val_addr); wdata = bus.mem_key_val_data_in;
            end
            if (bus.mem_state_var_we) begin
                writes++; wsel = 1'b1;
                waddr = int'(bus.mem_state_var_addr); wdata = bus.mem_state_var_data_in;
            end
            if (bus.code_ready) begin
                lat = cyc; code = bus.out_code; err = bus.error;
                break;
            end
        end
        @(negedge clock);
        ready_after = bus.code_ready;
    endtask

    task automatic runAndCheck(input string tag, input logic sel, input logic ow,
                               input logic [CW-1:0] oc, input logic [DW-1:0] val,
                               input logic [CW-1:0] exp_code, input logic exp_err,
                               input logic exp_wsel, input int exp_waddr);
        logic [CW-1:0] code;
        logic          err;
        int            lat;
        int            writes;
        logic          wsel;
        int            waddr;
        logic [DW-1:0] wdata;
        logic          ready_after;
        applyStimulus(sel, ow, oc, val, code, err, lat, writes, wsel, waddr, wdata, ready_after);
        checkOutput({tag, ".code"}, 32'(code), 32'(exp_code));
        checkOutput({tag, ".error"}, 32'(err), 32'(exp_err));
        checkOutput({tag, ".latency"}, lat, exp_err ? 1 : MEM_DELAY + 2);
        checkOutput({tag, ".writes"}, writes, exp_err ? 0 : 1);
        if (!exp_err && writes == 1) begin
            checkOutput({tag, ".wsel"}, 32'(wsel), 32'(exp_wsel));
            checkOutput({tag, ".waddr"}, waddr, exp_waddr);
            checkOutput({tag, ".wdata"}, wdata, val);
        end
        checkOutput({tag, ".ready_pulse"}, 32'(ready_after), 0);
        checkOutput({tag, ".key_full"}, 32'(bus.key_val_full), 32'(m_count[0] == 16));
        checkOutput({tag, ".state_full"}, 32'(bus.state_var_full), 32'(m_count[1] == 8));
    endtask

    // Allocate or overwrite with expectations taken from the reference model
    task automatic modelRun(input string tag, input logic sel, input logic ow,
                            input logic [CW-1:0] oc, input logic [DW-1:0] val);
        logic [CW-1:0] code;
        logic          err;
        logic          wsel;
        int            waddr;
        modelRequest(sel, ow, oc, code, err, wsel, waddr);
        runAndCheck(tag, sel, ow, oc, val, code, err, wsel, waddr);
    endtask

    task automatic pulseClear();
        bus.alloc_clear = 1'b1;
        @(posedge clock);
        #1 bus.alloc_clear = 1'b0;
        @(negedge clock);
        modelClear();
    endtask

    // Main test sequence
    initial begin
        int writes;
        int readys;
        int busy_cycles;
        int first_addr;
        int last_addr;

        for (int i = 0; i < 16; i++) dut_key_mem[i] = '0;
        for (int i = 0; i < 8; i++)  dut_state_mem[i] = '0;
        modelClear();

        vecs[0]  = '{1'b0, 1'b0, 8'h00, 32'hDEADBEEF, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 32'h11111111, 8'h01, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 32'h22222222, 8'h02, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, 32'h00000055, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h05, 32'h00000066, 8'h00, 1'b1};
        for (int i = 0; i < 8; i++) begin
            vecs[5+i] = '{1'b1, 1'b0, 8'h00, 32'h100 + 32'(i), 8'h20 + 8'(i), 1'b0};
        end
        vecs[13] = '{1'b1, 1'b0, 8'h00, 32'h00000108, 8'h00, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 8'h27, 32'hA5A5A5A5, 8'h27, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'h03, 32'h00000077, 8'h00, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 8'h22, 32'h000000C3, 8'h22, 1'b0};

        resetn             = 1'b0;
        bus.encode_start   = 1'b0;
        bus.inp_value      = '0;
        bus.inp_sel        = 1'b0;
        bus.overwrite      = 1'b0;
        bus.overwrite_code = '0;
        bus.alloc_clear    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset.busy", 32'(bus.busy), 0);
        checkOutput("reset.code_ready", 32'(bus.code_ready), 0);
        checkOutput("reset.error", 32'(bus.error), 0);
        checkOutput("reset.out_code", 32'(bus.out_code), 0);
        checkOutput("reset.key_we", 32'(bus.mem_key_val_we), 0);
        checkOutput("reset.state_we", 32'(bus.mem_state_var_we), 0);
        checkOutput("reset.key_full", 32'(bus.key_val_full), 0);
        checkOutput("reset.state_full", 32'(bus.state_var_full), 0);
        resetn = 1'b1;
        @(negedge clock);

        $display("[TB] vector table");
        for (int i = 0; i < 17; i++) begin
            logic [CW-1:0] mcode;
            logic          merr;
            logic          mws;
            int            mwa;
            modelRequest(vecs[i].sel, vecs[i].ow, vecs[i].oc, mcode, merr, mws, mwa);
            runAndCheck($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ow, vecs[i].oc,
                        vecs[i].value, vecs[i].exp_code, vecs[i].exp_err,
                        vecs[i].exp_code[SEL_BIT], int'(vecs[i].exp_code[3:0]));
        end
        checkOutput("readback.key0", dut_key_mem[0], 32'hDEADBEEF);
        checkOutput("readback.key1", dut_key_mem[1], 32'h00000055);
        checkOutput("readback.key2", dut_key_mem[2], 32'h22222222);
        checkOutput("readback.state0", dut_state_mem[0], 32'h00000100);
        checkOutput("readback.state2", dut_state_mem[2], 32'h000000C3);
        checkOutput("readback.state7", dut_state_mem[7], 32'hA5A5A5A5);

        $display("[TB] key_val fill and clear");
        for (int i = 3; i < 16; i++) begin
            modelRun($sformatf("fill%0d", i), 1'b0, 1'b0, 8'h00, 32'h1000 + 32'(i));
        end
        checkOutput("fill.key_full", 32'(bus.key_val_full), 1);
        runAndCheck("fill.overflow", 1'b0, 1'b0, 8'h00, 32'hBAD0BAD0, 8'h00, 1'b1, 1'b0, 0);
        pulseClear();
        checkOutput("clear.key_full", 32'(bus.key_val_full), 0);
        checkOutput("clear.state_full", 32'(bus.state_var_full), 0);
        modelRun("clear.first", 1'b0, 1'b0, 8'h00, 32'hC0DE0000);
        checkOutput("clear.first_mem", dut_key_mem[0], 32'hC0DE0000);

        $display("[TB] held encode_start");
        writes = 0; readys = 0; first_addr = -1; last_addr = -1;
        bus.inp_sel = 1'b0; bus.overwrite = 1'b0; bus.inp_value = 32'h0000AAAA;
        bus.encode_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            if (i == 9) #1 bus.encode_start = 1'b0;
            @(negedge clock);
            if (bus.mem_key_val_we) begin
                writes++;
                if (first_addr < 0) first_addr = int'(bus.mem_key_val_addr);
                last_addr = int'(bus.mem_key_val_addr);
            end
            if (bus.code_ready) readys++;
        end
        m_count[0] += 2;
        checkOutput("held.writes", writes, (10 + MEM_DELAY + 2) / (MEM_DELAY + 3));
        checkOutput("held.readys", readys, 2);
        checkOutput("held.first_addr", first_addr, 1);
        checkOutput("held.last_addr", last_addr, 2);
        checkOutput("held.last_code", 32'(bus.out_code), 32'h02);

        $display("[TB] start and clear while busy");
        writes = 0; readys = 0;
        bus.inp_sel = 1'b0; bus.overwrite = 1'b0; bus.inp_value = 32'h0000BBBB;
        bus.encode_start = 1'b1;
        @(posedge clock);
        #1 bus.encode_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (bus.mem_key_val_we || bus.mem_state_var_we) writes++;
            if (bus.code_ready) readys++;
            bus.encode_start = (c <= 4);
            bus.alloc_clear  = (c <= 4);
        end
        m_count[0]++;
        checkOutput("busy.writes", writes, 1);
        checkOutput("busy.readys", readys, 1);
        checkOutput("busy.code", 32'(bus.out_code), 32'h03);
        modelRun("busy.next", 1'b0, 1'b0, 8'h00, 32'h0000CCCC);

        $display("[TB] clear together with start in IDLE");
        writes = 0; busy_cycles = 0;
        bus.alloc_clear = 1'b1; bus.encode_start = 1'b1; bus.inp_sel = 1'b0;
        @(posedge clock);
        #1 begin bus.alloc_clear = 1'b0; bus.encode_start = 1'b0; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.mem_key_val_we || bus.mem_state_var_we) writes++;
            if (bus.busy) busy_cycles++;
        end
        modelClear();
        checkOutput("clrstart.writes", writes, 0);
        checkOutput("clrstart.busy", busy_cycles, 0);
        runAndCheck("clrstart.next", 1'b0, 1'b0, 8'h00, 32'h0000DDDD, 8'h00, 1'b0, 1'b0, 0);
        m_count[0] = 1;
        modelRun("clrstart.next2", 1'b0, 1'b0, 8'h00, 32'h0000EEEE);

        $display("[TB] reset during WAIT");
        readys = 0;
        bus.inp_sel = 1'b0; bus.overwrite = 1'b0; bus.inp_value = 32'h0000FFFF;
        bus.encode_start = 1'b1;
        @(posedge clock);
        #1 bus.encode_start = 1'b0;
        @(negedge clock);
        checkOutput("rstwait.we_seen", 32'(bus.mem_key_val_we), 1);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rstwait.busy", 32'(bus.busy), 0);
        checkOutput("rstwait.code_ready", 32'(bus.code_ready), 0);
        checkOutput("rstwait.error", 32'(bus.error), 0);
        checkOutput("rstwait.out_code", 32'(bus.out_code), 0);
        checkOutput("rstwait.key_we", 32'(bus.mem_key_val_we), 0);
        checkOutput("rstwait.key_addr", 32'(bus.mem_key_val_addr), 0);
        checkOutput("rstwait.key_data", bus.mem_key_val_data_in, 0);
        checkOutput("rstwait.state_we", 32'(bus.mem_state_var_we), 0);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (bus.code_ready) readys++;
        end
        checkOutput("rstwait.no_ready", readys, 0);
        modelClear();
        modelRun("rstwait.next", 1'b0, 1'b0, 8'h00, 32'h12345678);

        $display("[TB] random requests");
        for (int i = 0; i < 60; i++) begin
            logic          s;
            logic          ow;
            logic [CW-1:0] oc;
            if ($urandom_range(0, 9) == 0) begin
                pulseClear();
            end
            s  = 1'($urandom_range(0, 1));
            ow = ($urandom_range(0, 2) == 0);
            oc = CW'($urandom_range(0, 15)) | (s ? 8'h20 : 8'h00);
            modelRun($sformatf("rand%0d", i), s, ow, oc, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
